tff_counter: RTL and testbench
==============================

# tff_counter

Parametrised WIDTH-bit register built from per-bit T flip-flop cells, runtime-selectable as a parallel toggle register, a modulo up-counter or a modulo down-counter. It generalises the single-bit T flip-flop in the practical set to a multi-bit, loadable, modulus-limited block. It also supplies terminal-count and overflow indications for cascading and for downstream timers and dividers.

## Interface
- WIDTH, 4: register width in bits (≥1).
- MAX_COUNT, 2**WIDTH-1: modulus minus one; must satisfy 0 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at terminal; 1 = hold at terminal.

- clk  input  1  rising-edge clock.
- rst_n  input  1  **one clock; reset is asynchronous and active-low**; clears all state immediately.
- en  input  1  advance enable for toggle and count modes.
- mode  input  2  00 toggle, 01 count up, 10 count down, 11 hold.
- t_in  input  WIDTH  per-bit toggle mask, used only in toggle mode.
- load  input  1  synchronous parallel load; overrides en and mode.
- din  input  WIDTH  load value.
- q  output  WIDTH  register state.
- qbar  output  WIDTH  bitwise complement of q.
- tc  output  1  combinational terminal-count flag.
- ovf  output  1  registered one-cycle overflow/underflow pulse.

## Operation
- Priority each rising edge: rst_n low > load > (en & mode) > hold.
- load: q ← min(din, MAX_COUNT); ovf ← 0.
- Toggle mode (00, en=1): q ← q ^ t_in. No modulus clamp; the result may exceed MAX_COUNT. ovf ← 0.
- Up mode (01, en=1):
  - q < MAX_COUNT: q ← q+1.
  - q ≥ MAX_COUNT: terminal. q ← 0 when SATURATE=0; q holds when SATURATE=1. ovf ← 1.
- Down mode (10, en=1):
  - q > 0: q ← q−1. This includes q > MAX_COUNT, which decrements normally.
  - q = 0: terminal. q ← MAX_COUNT when SATURATE=0; q holds at 0 when SATURATE=1. ovf ← 1.
- Hold mode (11), or en=0 without load: q holds; ovf ← 0.
- tc = en & ~load & ((mode==01 & q ≥ MAX_COUNT) | (mode==10 & q==0)). tc is the cascade-enable for a following stage.
- Every bit is a T cell with T[i] = next[i] ^ q[i]. All arithmetic is WIDTH-bit unsigned; the ≥ comparison is unsigned.
- ovf fires on every enabled terminal-attempt cycle, including repeated attempts while saturated.

## Timing
- q, qbar and ovf are registered, with zero added latency: they update on the edge that samples the inputs.
- tc has zero latency and is combinational from q, en, load and mode.
- ovf is high for exactly the cycle following a terminal-attempt edge, unless that condition repeats on the next edge.
- Reset values: q = 0, qbar = all ones, ovf = 0. tc = en & (mode==10) while in reset.
- Reset asserted mid-count clears immediately, without waiting for clk. The first edge after rst_n rises acts on q = 0.
- MAX_COUNT = 0: up and down both sit at 0, and ovf pulses on every enabled cycle.
- A load coincident with the terminal condition wins; ovf stays 0.

## Structure
- Shared package tff_pkg holds the mode localparams: MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_HOLD=2'b11.
- Sub-module tff_bit: one-bit T flip-flop with async active-low reset, ports clk, rst_n, T, Q, Qbar. It is instantiated WIDTH times in a generate loop.
- Top level holds next-state selection, the load clamp, tc logic and the ovf register.

## Test plan
- WIDTH=4, MAX_COUNT=9, SATURATE=0. Pulse rst_n low mid-count at q=5 → q=0, qbar=4'hF and ovf=0 immediately, before the next clk edge.
- Up mode, en=1, 12 edges from 0 → q goes 1..9, then 0, 1, 2. tc is high while q=9. ovf is high only in the cycle after q 9→0.
- Down mode, en=1 from q=1 → q goes 0 then 9. tc is high at q=0. ovf pulses once.
- SATURATE=1, up mode from q=8, 3 edges → q goes 9, 9, 9. ovf is high after the 2nd and 3rd edges.
- Toggle mode from q=0: t_in=4'b1010, then 4'b1111, then en=0 → q goes 1010, 0101, 0101. tc=0 and ovf=0 throughout.
- load with din=4'hE → q=9 (clamped). Load with din=3 together with en=1, up mode at q=9 → q=3 and ovf=0.

Source files
------------

// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared mode encodings for the T flip-flop counter
package tff_pkg;
   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;
endpackage

// File: rtl/tff_bit.sv
// rtl/tff_bit.sv - single T flip-flop cell with async active-low reset
module tff_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic T,
   output logic Q,
   output logic Qbar
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         Q <= 1'b0;
      else if (T)
         Q <= ~Q;
   end

   assign Qbar = ~Q;
endmodule

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - loadable toggle / modulo up-down register built from T cells
module tff_counter
   import tff_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 2**WIDTH-1,
   parameter bit SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t_in,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             ovf
);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] t_vec;
   logic             ovf_d;
   logic             term_up;
   logic             term_dn;

   assign term_up = (q >= MAX_Q);
   assign term_dn = (q == '0);

   always_comb begin
      next_q = q;
      ovf_d  = 1'b0;
      if (load) begin
         next_q = (din > MAX_Q) ? MAX_Q : din;
      end else if (en) begin
         case (mode)
            MODE_TOGGLE: next_q = q ^ t_in;
            MODE_UP: begin
               if (term_up) begin
                  ovf_d  = 1'b1;
                  next_q = SATURATE ? q : '0;
               end else begin
                  next_q = q + 1'b1;
               end
            end
            MODE_DOWN: begin
               if (term_dn) begin
                  ovf_d  = 1'b1;
                  next_q = SATURATE ? q : MAX_Q;
               end else begin
                  next_q = q - 1'b1;
               end
            end
            default: next_q = q;
         endcase
      end
   end

   assign tc = en & ~load & (((mode == MODE_UP) & term_up) | ((mode == MODE_DOWN) & term_dn));

   // Each cell toggles exactly where the chosen next state differs from the present one.
   assign t_vec = next_q ^ q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_bit u_bit (
         .clk  (clk),
         .rst_n(rst_n),
         .T    (t_vec[i]),
         .Q    (q[i]),
         .Qbar (qbar[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else
         ovf <= ovf_d;
   end
endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - self-checking bench for tff_counter (wrap, saturate and zero-modulus builds)
module tb_tff_counter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b11;
   logic [3:0] t_in = 4'h0;
   logic       load = 1'b0;
   logic [3:0] din = 4'h0;

   logic [3:0] dq  [3];
   logic [3:0] dqb [3];
   logic       dtc [3];
   logic       dovf[3];

   int tests = 0;
   int fails = 0;

   // instance 0: max 9 wrap, instance 1: max 9 saturate, instance 2: max 0 wrap
   int cfg_max[3] = '{9, 9, 0};
   bit cfg_sat[3] = '{1'b0, 1'b1, 1'b0};
   int m_q[3];
   bit m_ovf[3];

   always #5 clk = ~clk;

   tff_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_in(t_in), .load(load), .din(din),
      .q(dq[0]), .qbar(dqb[0]), .tc(dtc[0]), .ovf(dovf[0]));
   tff_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_in(t_in), .load(load), .din(din),
      .q(dq[1]), .qbar(dqb[1]), .tc(dtc[1]), .ovf(dovf[1]));
   tff_counter #(.WIDTH(4), .MAX_COUNT(0), .SATURATE(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_in(t_in), .load(load), .din(din),
      .q(dq[2]), .qbar(dqb[2]), .tc(dtc[2]), .ovf(dovf[2]));

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: plain integer arithmetic on the rules, per configuration.
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            m_q[k] = 0;
            m_ovf[k] = 0;
         end else if (load) begin
            m_q[k] = (int'(din) > cfg_max[k]) ? cfg_max[k] : int'(din);
            m_ovf[k] = 0;
         end else if (en && mode == 2'b00) begin
            m_q[k] = m_q[k] ^ int'(t_in);
            m_ovf[k] = 0;
         end else if (en && mode == 2'b01) begin
            m_ovf[k] = (m_q[k] >= cfg_max[k]);
            if (m_ovf[k]) m_q[k] = cfg_sat[k] ? m_q[k] : 0;
            else m_q[k] = m_q[k] + 1;
         end else if (en && mode == 2'b10) begin
            m_ovf[k] = (m_q[k] == 0);
            if (m_ovf[k]) m_q[k] = cfg_sat[k] ? 0 : cfg_max[k];
            else m_q[k] = m_q[k] - 1;
         end else begin
            m_ovf[k] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         int exp_tc;
         exp_tc = (en && !load && ((mode == 2'b01 && m_q[k] >= cfg_max[k]) ||
                                   (mode == 2'b10 && m_q[k] == 0))) ? 1 : 0;
         check($sformatf("model_q[%0d]", k), int'(dq[k]), m_q[k]);
         check($sformatf("model_qbar[%0d]", k), int'(dqb[k]), 15 - m_q[k]);
         check($sformatf("model_tc[%0d]", k), int'(dtc[k]), exp_tc);
         check($sformatf("model_ovf[%0d]", k), int'(dovf[k]), int'(m_ovf[k]));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      #1;
      check("reset_q", int'(dq[0]), 0);
      check("reset_qbar", int'(dqb[0]), 15);
      check("reset_ovf", int'(dovf[0]), 0);
      step();
      rst_n = 1'b1;

      // count to 5 then pulse reset between edges
      en = 1'b1; mode = 2'b01;
      repeat (5) step();
      check("pre_reset_q", int'(dq[0]), 5);
      rst_n = 1'b0;
      #1;
      check("async_reset_q", int'(dq[0]), 0);
      check("async_reset_qbar", int'(dqb[0]), 15);
      check("async_reset_ovf", int'(dovf[0]), 0);
      check("reset_tc_up", int'(dtc[0]), 0);
      step();
      rst_n = 1'b1;

      // up count wrap from 0
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("up_q_%0d", i), int'(dq[0]), up_seq[i]);
         check($sformatf("up_ovf_%0d", i), int'(dovf[0]), (i == 9) ? 1 : 0);
         if (i == 8) check("up_tc_at_9", int'(dtc[0]), 1);
      end

      // down from 1
      load = 1'b1; din = 4'd1;
      step();
      load = 1'b0; mode = 2'b10;
      step();
      check("down_q_0", int'(dq[0]), 0);
      check("down_tc_at_0", int'(dtc[0]), 1);
      step();
      check("down_q_wrap", int'(dq[0]), 9);
      check("down_ovf", int'(dovf[0]), 1);
      step();
      check("down_q_8", int'(dq[0]), 8);
      check("down_ovf_clear", int'(dovf[0]), 0);

      // saturating instance from 8
      load = 1'b1; din = 4'd8; mode = 2'b01;
      step();
      load = 1'b0;
      step();
      check("sat_q_1", int'(dq[1]), 9);
      check("sat_ovf_1", int'(dovf[1]), 0);
      step();
      check("sat_q_2", int'(dq[1]), 9);
      check("sat_ovf_2", int'(dovf[1]), 1);
      step();
      check("sat_q_3", int'(dq[1]), 9);
      check("sat_ovf_3", int'(dovf[1]), 1);

      // toggle mode
      load = 1'b1; din = 4'd0;
      step();
      load = 1'b0; mode = 2'b00; t_in = 4'b1010;
      step();
      check("tog_q_1", int'(dq[0]), 4'b1010);
      t_in = 4'b1111;
      step();
      check("tog_q_2", int'(dq[0]), 4'b0101);
      check("tog_tc", int'(dtc[0]), 0);
      en = 1'b0;
      step();
      check("tog_q_hold", int'(dq[0]), 4'b0101);
      check("tog_ovf", int'(dovf[0]), 0);

      // load clamp, then load beating the terminal condition
      load = 1'b1; din = 4'hE;
      step();
      check("load_clamp", int'(dq[0]), 9);
      din = 4'd3; en = 1'b1; mode = 2'b01;
      check("load_masks_tc", int'(dtc[0]), 0);
      step();
      check("load_wins_q", int'(dq[0]), 3);
      check("load_wins_ovf", int'(dovf[0]), 0);
      load = 1'b0;

      // zero modulus: up and down sit at 0 and overflow every cycle
      step();
      check("m0_up_q", int'(dq[2]), 0);
      check("m0_up_ovf", int'(dovf[2]), 1);
      mode = 2'b10;
      step();
      check("m0_down_q", int'(dq[2]), 0);
      check("m0_down_ovf", int'(dovf[2]), 1);
      mode = 2'b11;
      step();
      check("hold_ovf", int'(dovf[2]), 0);
      check("hold_q", int'(dq[0]), 3);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
